// File: rtl/aud_track_ctrl.sv
// Multi-track record/play control FSM: sequences AudRecorder and AudDSP with
// single-cycle command pulses and keeps per-slot length/valid bookkeeping.
module aud_track_ctrl #(
  parameter int ADDR_W  = 20,
  parameter int TRACK_W = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_i2c_fin,
  input  logic                       i_key_rec,
  input  logic                       i_key_play,
  input  logic                       i_key_stop,
  input  logic [TRACK_W-1:0]         i_track_sel,
  input  logic                       i_loop,
  input  logic                       i_rec_wr,
  input  logic                       i_play_fin,
  output logic                       o_rec_start,
  output logic                       o_rec_pause,
  output logic                       o_rec_stop,
  output logic                       o_dsp_start,
  output logic                       o_dsp_pause,
  output logic                       o_dsp_stop,
  output logic [ADDR_W-1:0]          o_rec_addr,
  output logic [ADDR_W-1:0]          o_play_base,
  output logic [ADDR_W-TRACK_W:0]    o_play_len,
  output logic                       o_sram_we_n,
  output logic [(2**TRACK_W)-1:0]    o_track_valid,
  output logic [TRACK_W-1:0]         o_cur_track,
  output logic                       o_full,
  output logic [2:0]                 o_state
);
  localparam int N_TRACKS = 2**TRACK_W;
  localparam int SLOT_W   = ADDR_W - TRACK_W;
  localparam logic [SLOT_W:0] SLOT_DEPTH = {1'b1, {SLOT_W{1'b0}}};
  localparam logic [SLOT_W:0] SLOT_LAST  = {1'b0, {SLOT_W{1'b1}}};

  typedef enum logic [2:0] {
    S_INIT = 3'd0, S_IDLE = 3'd1, S_RECD = 3'd2,
    S_RECD_PAUSE = 3'd3, S_PLAY = 3'd4, S_PLAY_PAUSE = 3'd5
  } state_t;

  state_t                         state_q, state_d;
  logic [TRACK_W-1:0]             cur_track_q, cur_track_d;
  logic [SLOT_W:0]                wr_cnt_q, wr_cnt_d;
  logic [N_TRACKS-1:0][SLOT_W:0]  len_q, len_d;
  logic [N_TRACKS-1:0]            valid_q, valid_d;
  logic rec_start_q, rec_pause_q, rec_stop_q, dsp_start_q, dsp_pause_q, dsp_stop_q, full_q;
  logic rec_start_d, rec_pause_d, rec_stop_d, dsp_start_d, dsp_pause_d, dsp_stop_d, full_d;
  logic slot_full;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_INIT;
      cur_track_q <= '0;
      wr_cnt_q    <= '0;
      len_q       <= '0;
      valid_q     <= '0;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_track_q <= cur_track_d;
      wr_cnt_q    <= wr_cnt_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      rec_start_q <= rec_start_d;
      rec_pause_q <= rec_pause_d;
      rec_stop_q  <= rec_stop_d;
      dsp_start_q <= dsp_start_d;
      dsp_pause_q <= dsp_pause_d;
      dsp_stop_q  <= dsp_stop_d;
      full_q      <= full_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_track_d = cur_track_q;
    wr_cnt_d    = wr_cnt_q;
    len_d       = len_q;
    valid_d     = valid_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    full_d      = 1'b0;
    slot_full   = 1'b0;
    unique case (state_q)
      S_INIT: if (i_i2c_fin) state_d = S_IDLE;
      S_IDLE: begin
        if (i_key_stop) begin
          state_d = S_IDLE;
        end else if (i_key_rec) begin
          cur_track_d          = i_track_sel;
          wr_cnt_d             = '0;
          len_d[i_track_sel]   = '0;
          valid_d[i_track_sel] = 1'b0;
          rec_start_d          = 1'b1;
          state_d              = S_RECD;
        end else if (i_key_play) begin
          cur_track_d = i_track_sel;
          if (valid_q[i_track_sel]) begin
            dsp_start_d = 1'b1;
            state_d     = S_PLAY;
          end
        end
      end
      S_RECD: begin
        // saturating guard keeps the address inside the slot
        if (i_rec_wr && wr_cnt_q != SLOT_DEPTH) begin
          wr_cnt_d           = wr_cnt_q + 1'b1;
          len_d[cur_track_q] = len_q[cur_track_q] + 1'b1;
        end
        slot_full = i_rec_wr && (wr_cnt_q == SLOT_LAST);
        if (slot_full || i_key_stop) begin
          rec_stop_d           = 1'b1;
          full_d               = slot_full;
          valid_d[cur_track_q] = (len_d[cur_track_q] != '0);
          state_d              = S_IDLE;
        end else if (i_key_rec) begin
          rec_pause_d = 1'b1;
          state_d     = S_RECD_PAUSE;
        end
      end
      S_RECD_PAUSE: begin
        if (i_key_stop) begin
          rec_stop_d           = 1'b1;
          valid_d[cur_track_q] = (len_q[cur_track_q] != '0);
          state_d              = S_IDLE;
        end else if (i_key_rec) begin
          rec_start_d = 1'b1;
          state_d     = S_RECD;
        end
      end
      S_PLAY: begin
        if (i_key_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = S_IDLE;
        end else if (i_key_play) begin
          dsp_pause_d = 1'b1;
          state_d     = S_PLAY_PAUSE;
        end else if (i_play_fin) begin
          if (i_loop) dsp_start_d = 1'b1;
          else        state_d     = S_IDLE;
        end
      end
      S_PLAY_PAUSE: begin
        if (i_key_stop) begin
          dsp_stop_d = 1'b1;
          state_d    = S_IDLE;
        end else if (i_key_play) begin
          dsp_start_d = 1'b1;
          state_d     = S_PLAY;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    o_rec_start   = rec_start_q;
    o_rec_pause   = rec_pause_q;
    o_rec_stop    = rec_stop_q;
    o_dsp_start   = dsp_start_q;
    o_dsp_pause   = dsp_pause_q;
    o_dsp_stop    = dsp_stop_q;
    o_full        = full_q;
    o_rec_addr    = {cur_track_q, wr_cnt_q[SLOT_W-1:0]};
    o_play_base   = {cur_track_q, {SLOT_W{1'b0}}};
    o_play_len    = len_q[cur_track_q];
    o_sram_we_n   = (state_q != S_RECD);
    o_track_valid = valid_q;
    o_cur_track   = cur_track_q;
    o_state       = state_q;
  end
endmodule

// File: doc/aud_track_ctrl.md
Name: aud_track_ctrl

Overview:
Multi-track successor to the record/play top-level control FSM. Waits for codec I2C init, then sequences the recorder and DSP through record/pause/play/stop using single-cycle command pulses. SRAM is split into 2**TRACK_W equal slots; per-slot length and valid state are kept in registers. Adds slot-full auto-stop, a play-pause state, loop playback and rejection of play on empty tracks. Sits between the key/switch inputs and the AudRecorder/AudDSP instances.

Parameters:
ADDR_W, 20, SRAM word-address width.
TRACK_W, 2, track-index width; N_TRACKS = 2**TRACK_W, SLOT_W = ADDR_W-TRACK_W, SLOT_DEPTH = 2**SLOT_W samples.

Ports:
i_clk  in  1  system clock; the only clock.
i_rst  in  1  synchronous, active-high reset.
i_i2c_fin  in  1  codec init done (level).
i_key_rec  in  1  record / record-pause toggle, debounced 1-cycle pulse.
i_key_play  in  1  play / play-pause toggle, 1-cycle pulse.
i_key_stop  in  1  stop, 1-cycle pulse.
i_track_sel  in  TRACK_W  requested track.
i_loop  in  1  loop-playback enable (level).
i_rec_wr  in  1  recorder wrote one sample this cycle.
i_play_fin  in  1  DSP reached end of track, 1-cycle pulse.
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  recorder command pulses.
o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  DSP command pulses.
o_rec_addr  out  ADDR_W  {cur_track, wr_cnt[SLOT_W-1:0]}.
o_play_base  out  ADDR_W  {cur_track, SLOT_W'0}.
o_play_len  out  SLOT_W+1  stored length of cur_track.
o_sram_we_n  out  1  0 only in S_RECD.
o_track_valid  out  N_TRACKS  bit t = track t holds >=1 sample.
o_cur_track  out  TRACK_W  latched active track.
o_full  out  1  1-cycle pulse on slot-full auto-stop.
o_state  out  3  current state encoding.

Behaviour:
- States: S_INIT=0, S_IDLE=1, S_RECD=2, S_RECD_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5.
- Reset: state S_INIT; all pulses 0; wr_cnt 0; all lengths 0; o_track_valid 0; o_cur_track 0; o_sram_we_n 1. Reset mid-operation aborts immediately with no stop pulse.
- All command pulses and o_full are registered: high exactly one cycle, in the cycle after the triggering event. State changes on the same edge.
- Key priority when several keys pulse in one cycle: stop > rec > play.
- S_INIT: all keys ignored; go to S_IDLE the cycle after i_i2c_fin=1.
- S_IDLE, rec:
  - latch cur_track=i_track_sel; wr_cnt=0; len[cur_track]=0; valid bit cleared.
  - pulse o_rec_start; go to S_RECD.
- S_IDLE, play:
  - latch track.
  - If valid: pulse o_dsp_start; go to S_PLAY.
  - Else: stay in S_IDLE with no pulse.
- S_IDLE, stop: no effect.
- S_RECD:
  - i_rec_wr increments wr_cnt and len.
  - rec: pulse o_rec_pause; go to S_RECD_PAUSE.
  - stop: pulse o_rec_stop; valid=(len!=0); go to S_IDLE.
  - Full: when i_rec_wr and wr_cnt==SLOT_DEPTH-1, the write counts (len=SLOT_DEPTH). Then pulse o_rec_stop and o_full, set valid, go to S_IDLE. A same-cycle stop key yields one o_rec_stop only.
- S_RECD_PAUSE:
  - i_rec_wr ignored.
  - rec: pulse o_rec_start; go to S_RECD.
  - stop: as in S_RECD.
  - play ignored.
- S_PLAY:
  - play: pulse o_dsp_pause; go to S_PLAY_PAUSE.
  - stop: pulse o_dsp_stop; go to S_IDLE.
  - i_play_fin with i_loop=1: pulse o_dsp_start; stay in S_PLAY.
  - i_play_fin with i_loop=0: go to S_IDLE with no pulse.
  - Stop and i_play_fin together: stop wins.
- S_PLAY_PAUSE:
  - play: pulse o_dsp_start; go to S_PLAY.
  - stop: pulse o_dsp_stop; go to S_IDLE.
  - i_play_fin ignored.
- i_track_sel is sampled only on S_IDLE exit; changes elsewhere are ignored.
- wr_cnt and len saturate and never wrap into the next slot.

Test Plan:
- Reset, hold i_i2c_fin=0 for 50 cycles, pulse keys -> o_state stays 0 with no pulses; i_i2c_fin=1 -> o_state=1 next cycle.
- TRACK_W=2, track 2: rec, 10 i_rec_wr, stop -> o_rec_start then o_rec_stop one cycle each; o_track_valid=4'b0100; len[2]=10; o_rec_addr reached 0x8000A.
- Play on empty track 1 -> stays S_IDLE, no o_dsp_start. Play track 2, i_loop=1, i_play_fin twice -> two extra o_dsp_start pulses, state stays 4, o_play_len=10.
- ADDR_W=6, TRACK_W=2 (SLOT_DEPTH 16): record 16 writes -> o_full and o_rec_stop pulse once, len=16, S_IDLE; a 17th i_rec_wr has no effect.
- In S_RECD, rec+stop+play in the same cycle -> only o_rec_stop, S_IDLE. Pause/resume: i_rec_wr during pause leaves wr_cnt unchanged.
- Assert i_rst in S_PLAY -> next cycle o_state=0, o_track_valid=0, all pulses 0.
